// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request in, fixed-latency response pulse out.
// Ports: clk, reset (async, active-low), req_* request bundle, rsp_* response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT =
    {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_uns;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;

  logic        o_write;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [2:0]  o_size;
  logic        o_uns;

  logic        sz_b, sz_h, sz_w;
  logic        err;
  logic [AW-1:0] idx;
  logic [31:0] word;
  logic [31:0] sh;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] merged;
  logic [31:0] ld;
  logic        we;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (accept)
          state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:
        if (cnt == 4'd0)
          state_nxt = S_RESP;
      S_RESP:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  // With no wait states the access happens on the accept edge,
  // so the live request is used instead of the captured copy.
  assign o_write = (state == S_IDLE) ? req_write    : r_write;
  assign o_addr  = (state == S_IDLE) ? req_addr     : r_addr;
  assign o_wdata = (state == S_IDLE) ? req_wdata    : r_wdata;
  assign o_size  = (state == S_IDLE) ? req_size     : r_size;
  assign o_uns   = (state == S_IDLE) ? req_unsigned : r_uns;

  assign sz_b = (o_size == 3'd1);
  assign sz_h = (o_size == 3'd2);
  assign sz_w = (o_size == 3'd4);

  assign err = (sz_h && o_addr[0])
            || (sz_w && (o_addr[1:0] != 2'b00))
            || !(sz_b || sz_h || sz_w)
            || ({1'b0, o_addr} < {1'b0, ADDR_BASE})
            || ({1'b0, o_addr} >= LIMIT);

  assign idx  = AW'((o_addr - ADDR_BASE) >> 2);
  assign word = mem[idx];
  assign sh   = word >> {o_addr[1:0], 3'b000};

  always_comb begin
    be     = 4'b0000;
    wd_rep = o_wdata;
    ld     = 32'h0;
    unique case (1'b1)
      sz_b: begin
        be     = 4'b0001 << o_addr[1:0];
        wd_rep = {4{o_wdata[7:0]}};
        ld     = {{24{!o_uns && sh[7]}}, sh[7:0]};
      end
      sz_h: begin
        be     = o_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{o_wdata[15:0]}};
        ld     = {{16{!o_uns && sh[15]}}, sh[15:0]};
      end
      sz_w: begin
        be     = 4'b1111;
        wd_rep = o_wdata;
        ld     = word;
      end
      default: begin
        be     = 4'b0000;
        wd_rep = o_wdata;
        ld     = 32'h0;
      end
    endcase
  end

  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++)
      if (be[i])
        merged[8*i +: 8] = wd_rep[8*i +: 8];
  end

  assign we = enter_resp && o_write && !err && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      r_write   <= 1'b0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_size    <= 3'd0;
      r_uns     <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        cnt     <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata <= (err || o_write) ? 32'h0 : ld;
        rsp_err   <= err;
      end
    end
  end

  // RAM contents survive reset; only committed stores touch it.
  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= merged;
  end

endmodule
